// File: rtl/cordic_bcd_formatter.sv
// Sequential s0.9 to BCD display formatter.
// Shift-add scale by 1000/512, then double-dabble.
module cordic_bcd_formatter #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] value,
  output logic       sign,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DABBLE,
    FINISH
  } state_t;

  localparam logic [3:0] D3_RST =
    BLANK_LEADING ? 4'hF : 4'h0;

  state_t      state;
  logic        sign_q;
  logic [9:0]  mag;
  logic [3:0]  cnt;
  logic [19:0] prod;
  logic [26:0] dab;

  logic [19:0] addend;
  logic [19:0] prod_next;
  logic [26:0] adj;
  logic [9:0]  mag_in;

  // Partial product, running sum and BCD nibble correction
  always_comb begin
    addend = '0;
    if (cnt < 4'd10 && mag[cnt])
      addend = 20'd1000 << cnt;
    prod_next = prod + addend;
    mag_in = value[9] ? (~value + 10'd1) : value;
    adj = dab;
    for (int k = 0; k < 4; k++) begin
      if (dab[11+4*k +: 4] >= 4'd5)
        adj[11+4*k +: 4] = dab[11+4*k +: 4] + 4'd3;
    end
  end

  // Sequencer: capture, multiply, convert, publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      mag    <= '0;
      cnt    <= '0;
      prod   <= '0;
      dab    <= '0;
      sign   <= 1'b0;
      digit3 <= D3_RST;
      digit2 <= 4'h0;
      digit1 <= 4'h0;
      digit0 <= 4'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_q <= value[9];
            mag    <= mag_in;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          prod <= prod_next;
          if (cnt == 4'd9) begin
            dab   <= {16'h0, prod_next[19:9]};
            cnt   <= '0;
            state <= DABBLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DABBLE: begin
          dab <= {adj[25:0], 1'b0};
          if (cnt == 4'd10) begin
            state <= FINISH;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FINISH: begin
          sign   <= sign_q;
          digit2 <= dab[22:19];
          digit1 <= dab[18:15];
          digit0 <= dab[14:11];
          if (dab[26:23] == 4'h0)
            digit3 <= D3_RST;
          else
            digit3 <= dab[26:23];
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
